// File: rtl/seq_detector_pkg.sv
// Shared constants and the elaboration-time next-state table builder for seq_detector.
package seq_detector_pkg;

   localparam int unsigned DefLen = 4;
   localparam logic [DefLen-1:0] DefPattern = 4'b0110;

   localparam int unsigned MaxLen = 16;
   // Widest state code (clog2(MaxLen + 1)); one table row per {state, x} code.
   localparam int unsigned MaxStW = 5;
   localparam int unsigned MaxRows = 2 ** (MaxStW + 1);

   typedef logic [MaxRows*MaxStW-1:0] table_t;

   // Pattern bit i counted from the first bit received (the MSB).
   function automatic logic pat_bit(logic [MaxLen-1:0] pattern, int unsigned len, int unsigned i);
      logic [3:0] idx;
      idx = 4'(len - 1 - i);
      return pattern[idx];
   endfunction

   // Longest prefix of the pattern that is a suffix of (first k pattern bits, b).
   // From the detect state the match may not be the whole history, so it stays proper.
   function automatic int unsigned next_of(logic [MaxLen-1:0] pattern, int unsigned len,
                                           bit overlap, int unsigned k_in, logic b);
      int unsigned k;
      int unsigned n;
      int unsigned best;
      logic ok;
      logic s;
      k = (k_in == len && !overlap) ? 0 : k_in;
      n = k + 1;
      best = 0;
      for (int unsigned j = 1; j <= MaxLen; j++) begin
         if (j <= n && j <= len) begin
            ok = 1'b1;
            for (int unsigned t = 0; t < MaxLen; t++) begin
               if (t < j) begin
                  s = (n - j + t < k) ? pat_bit(pattern, len, n - j + t) : b;
                  if (s != pat_bit(pattern, len, t)) ok = 1'b0;
               end
            end
            if (ok) best = j;
         end
      end
      return best;
   endfunction

   // Row {state, x} holds the next state; rows for codes above len stay 0.
   function automatic table_t build_table(logic [MaxLen-1:0] pattern, int unsigned len,
                                          bit overlap);
      table_t tbl;
      tbl = '0;
      for (int unsigned k = 0; k < 2 ** MaxStW; k++) begin
         for (int unsigned b = 0; b < 2; b++) begin
            if (k <= len) begin
               tbl[(k * 2 + b) * MaxStW +: MaxStW] =
                  MaxStW'(next_of(pattern, len, overlap, k, 1'(b)));
            end
         end
      end
      return tbl;
   endfunction

endpackage

// File: rtl/seq_detector_if.sv
// Serial-in / detect-out bundle for the sequence detector.
interface seq_detector_if;

   logic x;
   logic z;

   modport master (output x, input z);
   modport slave (input x, output z);

endinterface

// File: rtl/seq_detector_next.sv
// Combinational next-state lookup; the table is built once at elaboration from PATTERN.
module seq_detector_next
   import seq_detector_pkg::*;
#(
   parameter int unsigned LEN = DefLen,
   parameter logic [LEN-1:0] PATTERN = DefPattern,
   parameter bit OVERLAP = 1'b1,
   localparam int unsigned StW = $clog2(LEN + 1)
) (
   input  logic [StW-1:0] state,
   input  logic           x,
   output logic [StW-1:0] state_next
);

   localparam table_t Table = build_table(MaxLen'(PATTERN), LEN, OVERLAP);

   logic [MaxStW:0] row;

   // Look up the next state; illegal codes above S(LEN) fall back to S0.
   always_comb begin
      row = {MaxStW'(state), x};
      state_next = '0;
      if (state <= StW'(LEN)) begin
         state_next = StW'(Table[row * MaxStW +: MaxStW]);
      end
   end

endmodule

// File: rtl/seq_detector.sv
// Moore serial pattern detector: z is registered and high only in the detect state S(LEN).
module seq_detector
   import seq_detector_pkg::*;
#(
   parameter int unsigned LEN = DefLen,
   parameter logic [LEN-1:0] PATTERN = DefPattern,
   parameter bit OVERLAP = 1'b1
) (
   input  logic x,
   input  logic clk,
   input  logic rst,
   output logic z
);

   localparam int unsigned StW = $clog2(LEN + 1);
   localparam logic [StW-1:0] Detect = StW'(LEN);

   logic [StW-1:0] state_q;
   logic [StW-1:0] state_d;
   logic           x_s;

   // Unknown or floating serial input counts as 0.
   always_comb begin
      x_s = (x === 1'b1);
   end

   seq_detector_next #(
      .LEN     (LEN),
      .PATTERN (PATTERN),
      .OVERLAP (OVERLAP)
   ) u_next (
      .state      (state_q),
      .x          (x_s),
      .state_next (state_d)
   );

   // State and detect flag; z tracks the state it is loaded alongside.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= '0;
         z       <= 1'b0;
      end else begin
         state_q <= state_d;
         z       <= (state_d == Detect);
      end
   end

endmodule

// File: tb/tb_seq_detector.sv
// Bench for seq_detector: default pattern with and without overlap, plus a 5-bit pattern.
module tb_seq_detector;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   seq_detector_if bus_ov ();
   seq_detector_if bus_no ();
   seq_detector_if bus_l5 ();

   seq_detector #(
      .LEN     (4),
      .PATTERN (4'b0110),
      .OVERLAP (1'b1)
   ) dut_ov (
      .x   (bus_ov.x),
      .clk (clk),
      .rst (rst),
      .z   (bus_ov.z)
   );

   seq_detector #(
      .LEN     (4),
      .PATTERN (4'b0110),
      .OVERLAP (1'b0)
   ) dut_no (
      .x   (bus_no.x),
      .clk (clk),
      .rst (rst),
      .z   (bus_no.z)
   );

   seq_detector #(
      .LEN     (5),
      .PATTERN (5'b10101),
      .OVERLAP (1'b1)
   ) dut_l5 (
      .x   (bus_l5.x),
      .clk (clk),
      .rst (rst),
      .z   (bus_l5.z)
   );

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   // Reference model: raw bit history plus counts of bits seen since reset / since restart.
   logic [15:0] hist;
   int unsigned seen;
   int unsigned since_no;
   logic        exp_ov, exp_no, exp_l5;
   logic [31:0] trace_ov, trace_no, trace_l5;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Last len bits equal the pattern and all of them arrived after the last restart.
   function automatic logic window_match(logic [15:0] h, int unsigned len, logic [15:0] pat,
                                         int unsigned avail);
      logic [15:0] mask;
      mask = (16'h1 << len) - 16'h1;
      return (avail >= len) && ((h & mask) == (pat & mask));
   endfunction

   task automatic model_reset();
      hist     = '0;
      seen     = 0;
      since_no = 0;
      exp_ov   = 1'b0;
      exp_no   = 1'b0;
      exp_l5   = 1'b0;
   endtask

   task automatic model_push(input logic b);
      hist = {hist[14:0], b};
      if (seen < 1000) seen++;
      since_no++;
      exp_ov = window_match(hist, 4, 16'h0006, seen);
      exp_no = window_match(hist, 4, 16'h0006, since_no);
      if (exp_no) since_no = 0;
      exp_l5 = window_match(hist, 5, 16'h0015, seen);
   endtask

   task automatic step(input logic b, input string tag);
      bus_ov.x = b;
      bus_no.x = b;
      bus_l5.x = b;
      @(posedge clk);
      #1;
      model_push(b);
      check({tag, "_ov"}, 32'(bus_ov.z), 32'(exp_ov));
      check({tag, "_no"}, 32'(bus_no.z), 32'(exp_no));
      check({tag, "_l5"}, 32'(bus_l5.z), 32'(exp_l5));
      trace_ov = {trace_ov[30:0], bus_ov.z};
      trace_no = {trace_no[30:0], bus_no.z};
      trace_l5 = {trace_l5[30:0], bus_l5.z};
   endtask

   // Reset is asserted between edges, held across one edge, released at a falling edge.
   task automatic do_reset(input string tag);
      #2;
      rst = 1'b0;
      #1;
      check({tag, "_async_ov"}, 32'(bus_ov.z), 32'd0);
      check({tag, "_async_no"}, 32'(bus_no.z), 32'd0);
      check({tag, "_async_l5"}, 32'(bus_l5.z), 32'd0);
      @(posedge clk);
      #1;
      check({tag, "_held_ov"}, 32'(bus_ov.z), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      trace_ov = '0;
      trace_no = '0;
      trace_l5 = '0;
   endtask

   task automatic run_bits(input logic [31:0] bits, input int unsigned n, input string tag);
      for (int i = int'(n) - 1; i >= 0; i--) begin
         step(bits[i], tag);
      end
   endtask

   initial begin
      logic any_z;
      bus_ov.x = 1'b0;
      bus_no.x = 1'b0;
      bus_l5.x = 1'b0;
      model_reset();
      trace_ov = '0;
      trace_no = '0;
      trace_l5 = '0;

      // Power-on reset
      #3;
      check("por_ov", 32'(bus_ov.z), 32'd0);
      check("por_no", 32'(bus_no.z), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // 0,1,1,0: one detect right after the fourth edge, then back low
      run_bits(32'b0110, 4, "basic");
      check("basic_trace_ov", trace_ov & 32'hF, 32'b0001);
      check("basic_trace_no", trace_no & 32'hF, 32'b0001);
      step(1'b0, "basic_after");
      check("basic_drop_ov", 32'(bus_ov.z), 32'd0);

      // Overlapping stream: detects after bits 5, 8, 12 (overlap) and 5, 12 (restart)
      do_reset("rst1");
      run_bits(32'b001101100110, 12, "stream");
      check("stream_trace_ov", trace_ov & 32'hFFF, 32'b000010010001);
      check("stream_trace_no", trace_no & 32'hFFF, 32'b000010000001);

      // Near miss before the real match
      do_reset("rst2");
      run_bits(32'b01110110, 8, "miss");
      check("miss_trace_ov", trace_ov & 32'hFF, 32'b00000001);
      check("miss_trace_no", trace_no & 32'hFF, 32'b00000001);

      // Asynchronous reset drops a live detect without a clock edge
      do_reset("rst3");
      run_bits(32'b0110, 4, "pre_async");
      check("pre_async_z", 32'(bus_ov.z), 32'd1);
      do_reset("async_hit");

      // Reset after 0,1,1 discards history: a following 0 must not detect
      run_bits(32'b011, 3, "partial");
      do_reset("mid_seq");
      run_bits(32'b0110, 4, "post_mid");
      check("post_mid_trace_ov", trace_ov & 32'hF, 32'b0001);
      check("post_mid_trace_no", trace_no & 32'hF, 32'b0001);

      // Long runs of ones then zeros never detect
      do_reset("rst4");
      any_z = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step((i < 20) ? 1'b1 : 1'b0, "const");
         any_z = any_z | bus_ov.z | bus_no.z;
      end
      check("const_any_z", 32'(any_z), 32'd0);

      // Random stream with occasional resets
      do_reset("rst5");
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 79) == 0) begin
            do_reset("rand_rst");
         end
         step(1'($urandom_range(0, 1)), "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/seq_detector.md
SEQ_DETECTOR -- requirements
Module: seq_detector

Interface
REQ-001 Parameter LEN, default 4: pattern length in bits, legal range 2..16.
REQ-002 Parameter PATTERN, default 4'b0110, width LEN: target serial sequence; the MSB is the first bit received.
REQ-003 Parameter OVERLAP, default 1: 1 = overlapping detection, 0 = the detector restarts after each match.
REQ-004 clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-006 x  input  1  serial data bit, sampled on each rising clk edge.
REQ-007 z  output  1  detect flag, registered.
REQ-008 Positional port order SHALL be x, clk, rst, z.

Function
REQ-009 Machine type SHALL be Moore: z is a pure function of the state register, with no combinational path from x to z.
REQ-010 States SHALL be S0..S(LEN); Sk means the last k sampled bits equal the first k bits of PATTERN.
REQ-011 State S(LEN) is the detect state; z SHALL be 1 only in S(LEN).
REQ-012 Latency: z SHALL rise on the same clk edge that samples the final pattern bit, and stay high for exactly one cycle unless the next sample completes another match.
REQ-013 Transitions SHALL follow the KMP longest-proper-prefix-that-is-a-suffix rule, computed at elaboration from PATTERN.
REQ-014 Default transition table, next state for x=0 / x=1:
- S0: S1 / S0
- S1: S1 / S2
- S2: S1 / S3
- S3: S4 / S0
- S4 with OVERLAP=1: S1 / S2
- S4 with OVERLAP=0: S1 / S0
REQ-015 With OVERLAP=0, the transition out of S(LEN) SHALL be computed as if from S0.
REQ-016 An x value of X or Z while out of reset SHALL be treated as 0.
REQ-017 There SHALL be no unreachable or lock-up state; illegal state encodings SHALL return to S0 on the next edge.

Reset
REQ-018 rst=0 SHALL asynchronously force state S0 and z=0, independent of clk.
REQ-019 Release of rst SHALL be honored on the first rising clk edge at which rst=1.
REQ-020 Reset asserted mid-sequence SHALL discard all partial-match history.

Structure
REQ-021 A shared package seq_detector_pkg SHALL hold the default LEN/PATTERN constants and the function that builds the next-state table.
REQ-022 A single sub-module, seq_detector_next (combinational next-state and table logic), is natural; the state register and z register SHALL stay in seq_detector.
REQ-023 State encoding SHALL be binary, with width clog2(LEN+1).

Verification
REQ-024 Apply reset, then x=0,1,1,0 on successive edges -> z=1 in the cycle after the 4th edge only.
REQ-025 Stream 0,0,1,1,0,1,1,0,0,1,1,0 after reset with OVERLAP=1 -> z=1 after bits 5, 8 and 12 only.
REQ-026 Same stream with OVERLAP=0 -> z=1 after bits 5 and 12 only; the bit-8 match is suppressed because its leading 0 is consumed by the first match.
REQ-027 Stream 0,1,1,1,0,1,1,0 -> z=0 until bit 8, then z=1 once.
REQ-028 Pull rst low between clock edges after 0,1,1 -> z=0 and state S0 immediately; a following 0 -> S1, with no spurious detect.
REQ-029 Constant x=1 for 20 cycles, then constant x=0 for 20 cycles -> z stays 0 throughout.
